// File: rtl/mem_dumper_pkg.sv
// mem_dumper_pkg: shared types and constants for the memory dump unit.
// Provides the FSM state encoding, the trailer byte and the UART guard length.
package mem_dumper_pkg;

    localparam int          DEF_ADDR_WIDTH = 12;
    localparam int          DEF_CNT_WIDTH  = 12;
    localparam logic [7:0]  TRAILER_BYTE   = 8'hFF;
    // UART busy lags tx_en by one cycle, so tx_ready is ignored this long.
    localparam logic [1:0]  GUARD_CYCLES   = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        NEXT,
        REQ,
        READ,
        SEND_HI,
        SEND_LO,
        TRAIL_HI,
        TRAIL_LO,
        FINISH
    } dump_state_t;

endpackage

// File: rtl/mem_dumper_tx_byte_gate.sv
// tx_byte_gate: hands one byte at a time to the UART, honouring tx_ready
// plus a post-pulse guard window.
// Ports: i_clk, i_rst (async, active high), i_send (byte pending), i_byte,
//        i_tx_ready (UART idle), o_accept (combinational: byte taken this
//        cycle), o_tx_data / o_tx_en (registered UART load port).
module tx_byte_gate
    import mem_dumper_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_send,
    input  logic [7:0] i_byte,
    input  logic       i_tx_ready,
    output logic       o_accept,
    output logic [7:0] o_tx_data,
    output logic       o_tx_en
);

    logic [1:0] r_guard;
    logic [7:0] r_tx_data;
    logic       r_tx_en;
    logic       w_accept;

    assign w_accept = i_send && i_tx_ready && (r_guard == 2'd0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_guard   <= 2'd0;
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
        end else begin
            r_tx_en <= w_accept;
            if (w_accept) begin
                r_tx_data <= i_byte;
                r_guard   <= GUARD_CYCLES;
            end else if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end
        end
    end

    assign o_accept  = w_accept;
    assign o_tx_data = r_tx_data;
    assign o_tx_en   = r_tx_en;

endmodule

// File: rtl/mem_dumper.sv
// mem_dumper: reads word_count 16-bit words from memory and streams them to
// the UART high byte first, optionally followed by an FF FF trailer.
// Ports: i_clk, i_rst (async, active high); i_start/i_start_addr/i_word_count
//        command; o_busy/o_done status; o_mem_req/i_mem_gnt/o_mem_addr/
//        i_mem_rd_data bus requester; o_tx_data/o_tx_en/i_tx_ready UART.
module mem_dumper
    import mem_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter bit TRAILER    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [CNT_WIDTH-1:0]  i_word_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [15:0]           i_mem_rd_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_en,
    input  logic                  i_tx_ready
);

    dump_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [15:0]           r_buf;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic                  w_send;
    logic [7:0]            w_byte;
    logic                  w_accept;
    logic                  w_unused;

    // Words live at even addresses; bit 0 of the start address is dropped.
    assign w_unused = i_start_addr[0];

    always_comb begin
        w_send = 1'b0;
        w_byte = TRAILER_BYTE;
        unique case (r_state)
            SEND_HI: begin
                w_send = 1'b1;
                w_byte = r_buf[15:8];
            end
            SEND_LO: begin
                w_send = 1'b1;
                w_byte = r_buf[7:0];
            end
            TRAIL_HI, TRAIL_LO: w_send = 1'b1;
            default: ;
        endcase
    end

    tx_byte_gate u_gate (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_send     (w_send),
        .i_byte     (w_byte),
        .i_tx_ready (i_tx_ready),
        .o_accept   (w_accept),
        .o_tx_data  (o_tx_data),
        .o_tx_en    (o_tx_en)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_count    <= '0;
            r_buf      <= 16'h0000;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_addr  <= {i_start_addr[ADDR_WIDTH-1:1], 1'b0};
                        r_count <= i_word_count;
                        r_busy  <= 1'b1;
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_count == '0) begin
                        r_state <= TRAILER ? TRAIL_HI : FINISH;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    // Keep requesting until the arbiter grants.
                    if (i_mem_gnt) begin
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_buf      <= i_mem_rd_data;
                    r_mem_req  <= 1'b0;
                    r_mem_addr <= '0;
                    r_state    <= SEND_HI;
                end
                SEND_HI: begin
                    if (w_accept) begin
                        r_state <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (w_accept) begin
                        r_addr  <= r_addr + ADDR_WIDTH'(2);
                        r_count <= r_count - CNT_WIDTH'(1);
                        r_state <= NEXT;
                    end
                end
                TRAIL_HI: begin
                    if (w_accept) begin
                        r_state <= TRAIL_LO;
                    end
                end
                TRAIL_LO: begin
                    if (w_accept) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;

endmodule

// File: tb/tb_mem_dumper.sv
// tb_mem_dumper: scoreboard bench for mem_dumper with a synchronous memory
// model, a TRAILER=1 instance for most cases and a TRAILER=0 instance.
module tb_mem_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] sa;
    logic [11:0] wc;
    logic        gnt;
    logic [15:0] rd = 16'h0000;
    logic        ready;
    logic        busy, done, req, txe;
    logic [11:0] addr;
    logic [7:0]  txd;

    logic        z_start;
    logic [11:0] z_sa, z_wc;
    logic        z_busy, z_done, z_req, z_txe;
    logic [11:0] z_addr;
    logic [7:0]  z_txd;
    logic [15:0] z_rd = 16'h0000;

    logic [15:0] mem [0:2047];

    always #5 clk = ~clk;

    mem_dumper #(.ADDR_WIDTH(12), .CNT_WIDTH(12), .TRAILER(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_addr(sa),
        .i_word_count(wc), .o_busy(busy), .o_done(done), .o_mem_req(req),
        .i_mem_gnt(gnt), .o_mem_addr(addr), .i_mem_rd_data(rd),
        .o_tx_data(txd), .o_tx_en(txe), .i_tx_ready(ready)
    );

    mem_dumper #(.ADDR_WIDTH(12), .CNT_WIDTH(12), .TRAILER(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(z_start), .i_start_addr(z_sa),
        .i_word_count(z_wc), .o_busy(z_busy), .o_done(z_done), .o_mem_req(z_req),
        .i_mem_gnt(1'b1), .o_mem_addr(z_addr), .i_mem_rd_data(z_rd),
        .o_tx_data(z_txd), .o_tx_en(z_txe), .i_tx_ready(1'b1)
    );

    always @(posedge clk) begin
        if (req && gnt) rd <= mem[addr[11:1]];
        if (z_req) z_rd <= mem[z_addr[11:1]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int tx_times[$];
    int tx_cnt = 0, done_cnt = 0, done_cyc = 0, bus_cnt = 0, last_tx = -100;
    logic prev_ready = 1'b1;
    logic [7:0] mon_e;
    logic [7:0] z_bytes[$];
    int z_tx = 0, z_done_cnt = 0, z_done_cyc = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every tx_en and checks bus rules.
    always @(negedge clk) begin
        if (!rst) begin
            if (txe) begin
                tx_cnt++;
                tx_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_tx", int'(txd), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk(txd === mon_e, "tx_byte", int'(txd), int'(mon_e));
                end
                chk(prev_ready, "tx_while_not_ready", 1, 0);
                chk(cyc - last_tx >= 3, "tx_spacing", cyc - last_tx, 3);
                last_tx = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (req && gnt) bus_cnt++;
            if (req ? addr[0] : (addr != 12'h000))
                chk(1'b0, "mem_addr_rule", int'(addr), 0);
            if (z_txe) begin
                z_tx++;
                z_bytes.push_back(z_txd);
            end
            if (z_done) begin
                z_done_cnt++;
                z_done_cyc = cyc;
            end
        end
        prev_ready = ready;
    end

    task automatic push3(input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back(a);
        exp_q.push_back(b);
    endtask

    task automatic run_dump(input logic [11:0] a, input logic [11:0] n,
                            input int glitch, output int t_start);
        int d0 = done_cnt;
        int k = 0;
        @(posedge clk); #1;
        sa = a; wc = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t_start = cyc;
        chk(busy === 1'b1, "busy_after_start", int'(busy), 1);
        while (done_cnt == d0 && k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (glitch > 0 && k == glitch) begin
                sa = a + 12'h010; wc = 12'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk(done_cnt != d0, "done_timeout", k, 2000);
        repeat (4) @(posedge clk);
        #1;
        chk(done_cnt == d0 + 1, "done_once", done_cnt - d0, 1);
        chk(exp_q.size() == 0, "bytes_left", exp_q.size(), 0);
        chk(busy === 1'b0, "busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        chk(1'b0, "global_timeout", cyc, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int ts, n0, k;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
        mem[12'h300 >> 1] = 16'h1234;
        mem[12'h302 >> 1] = 16'hABCD;
        mem[12'hFFE >> 1] = 16'hBEEF;
        mem[0]            = 16'hCAFE;
        mem[12'h310 >> 1] = 16'h0F1E;
        rst = 1'b1; start = 1'b0; sa = '0; wc = '0; gnt = 1'b1; ready = 1'b1;
        z_start = 1'b0; z_sa = '0; z_wc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk({busy, done, req, addr, txd, txe} == '0, "reset_outputs",
            int'({busy, done, req, addr, txd, txe}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic dump with timing
        push3(8'h12, 8'h34); push3(8'hAB, 8'hCD); push3(8'hFF, 8'hFF);
        tx_times.delete(); bus_cnt = 0;
        run_dump(12'h300, 12'd2, 0, ts);
        chk(tx_times.size() == 6, "basic_tx_count", tx_times.size(), 6);
        chk(bus_cnt == 4, "basic_bus_cycles", bus_cnt, 4);
        if (tx_times.size() == 6) begin
            chk(tx_times[0] - ts == 4, "first_latency", tx_times[0] - ts, 4);
            chk(tx_times[1] - tx_times[0] == 3, "gap_hi_lo", tx_times[1] - tx_times[0], 3);
            chk(tx_times[2] - tx_times[1] == 4, "gap_word", tx_times[2] - tx_times[1], 4);
            chk(tx_times[4] - tx_times[3] == 3, "gap_trail", tx_times[4] - tx_times[3], 3);
            chk(tx_times[5] - tx_times[4] == 3, "gap_trail2", tx_times[5] - tx_times[4], 3);
            chk(done_cyc > tx_times[5] && done_cyc - tx_times[5] <= 2,
                "done_after_last", done_cyc - tx_times[5], 2);
        end

        // Zero count with trailer
        push3(8'hFF, 8'hFF);
        n0 = tx_cnt; bus_cnt = 0;
        run_dump(12'h300, 12'd0, 0, ts);
        chk(tx_cnt - n0 == 2, "zero_tx_count", tx_cnt - n0, 2);
        chk(bus_cnt == 0, "zero_bus", bus_cnt, 0);

        // Zero count without trailer
        @(posedge clk); #1;
        z_sa = 12'h300; z_wc = 12'd0; z_start = 1'b1;
        @(posedge clk); #1;
        z_start = 1'b0; ts = cyc;
        k = 0;
        while (z_done_cnt == 0 && k < 50) begin @(posedge clk); #1; k++; end
        chk(z_done_cnt == 1, "notrail_done", z_done_cnt, 1);
        chk(z_done_cyc - ts == 2, "notrail_done_lat", z_done_cyc - ts, 2);
        chk(z_tx == 0, "notrail_no_tx", z_tx, 0);

        // One word without trailer
        @(posedge clk); #1;
        z_sa = 12'h302; z_wc = 12'd1; z_start = 1'b1;
        @(posedge clk); #1;
        z_start = 1'b0;
        k = 0;
        while (z_done_cnt == 1 && k < 50) begin @(posedge clk); #1; k++; end
        chk(z_tx == 2, "notrail_word_tx", z_tx, 2);
        if (z_bytes.size() == 2) begin
            chk(z_bytes[0] == 8'hAB, "notrail_hi", int'(z_bytes[0]), 'hAB);
            chk(z_bytes[1] == 8'hCD, "notrail_lo", int'(z_bytes[1]), 'hCD);
        end
        chk(z_busy === 1'b0, "notrail_idle", int'(z_busy), 0);

        // Odd start address and wrap
        push3(8'hBE, 8'hEF); push3(8'hCA, 8'hFE); push3(8'hFF, 8'hFF);
        bus_cnt = 0;
        run_dump(12'hFFF, 12'd2, 0, ts);
        chk(bus_cnt == 4, "wrap_bus_cycles", bus_cnt, 4);

        // Backpressure and grant delay
        push3(8'h0F, 8'h1E); push3(8'hFF, 8'hFF);
        gnt = 1'b0; ready = 1'b0; bus_cnt = 0; n0 = tx_cnt;
        fork
            run_dump(12'h310, 12'd1, 0, ts);
            begin
                repeat (3) @(posedge clk);
                for (int i = 0; i < 10; i++) begin
                    #1;
                    if (!req) chk(1'b0, "req_held", int'(req), 1);
                    @(posedge clk);
                end
                #1;
                chk(req === 1'b1, "req_held_end", int'(req), 1);
                gnt = 1'b1;
                repeat (40) @(posedge clk);
                #1;
                chk(tx_cnt == n0, "no_tx_while_busy", tx_cnt - n0, 0);
                ready = 1'b1;
            end
        join
        chk(bus_cnt == 2, "bp_bus_cycles", bus_cnt, 2);
        chk(tx_cnt - n0 == 4, "bp_tx_count", tx_cnt - n0, 4);

        // Start pulse mid-dump is ignored
        push3(8'h12, 8'h34); push3(8'hFF, 8'hFF);
        n0 = tx_cnt;
        run_dump(12'h300, 12'd1, 6, ts);
        chk(tx_cnt - n0 == 4, "glitch_tx_count", tx_cnt - n0, 4);

        // Reset right after the high byte
        exp_q.push_back(8'h12);
        n0 = tx_cnt;
        @(posedge clk); #1;
        sa = 12'h300; wc = 12'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (tx_cnt == n0 && k < 50) begin @(posedge clk); #1; k++; end
        chk(tx_cnt == n0 + 1, "rst_hi_seen", tx_cnt - n0, 1);
        rst = 1'b1;
        #1;
        chk({busy, done, req, addr, txd, txe} == '0, "rst_async_outputs",
            int'({busy, done, req, addr, txd, txe}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk(tx_cnt == n0 + 1, "no_tx_after_rst", tx_cnt - n0, 1);

        push3(8'h12, 8'h34); push3(8'hAB, 8'hCD); push3(8'hFF, 8'hFF);
        n0 = tx_cnt;
        run_dump(12'h300, 12'd2, 0, ts);
        chk(tx_cnt - n0 == 6, "post_rst_tx_count", tx_cnt - n0, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
